alu_divider: RTL

- Multi-cycle 8-bit integer divider: the inverse companion of the combinational ALU multiply unit.
- Sits beside the ALU in the execute stage and handles DIV/REM.
- Stalls the CPU through BUSYWAIT, using the same stall mechanism as the data cache.
- Restoring algorithm, one quotient bit per clock; signed and unsigned modes.

---
 rtl/alu_divider_pkg.sv | 22 ++
 rtl/alu_divider_if.sv | 38 +++
 rtl/alu_divider_div_step.sv | 31 +++
 rtl/alu_divider.sv | 121 ++++++++++++
 4 files changed

// File: rtl/alu_divider_pkg.sv
`timescale 1ns/100ps
// alu_divider_pkg
//   Shared definitions for the execute-stage divider: FSM state encoding,
//   default operand width and the DIV/REM decode constants used by the ALU
//   and control unit when steering an operation to the divider.
package alu_divider_pkg;

    localparam int DIV_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        FIX  = 2'b10
    } div_state_e;

    // Instruction opcodes that route to the divider, and the ALU result
    // select that picks the divider output.
    localparam logic [7:0] OP_DIV      = 8'h0E;
    localparam logic [7:0] OP_REM      = 8'h0F;
    localparam logic [2:0] ALU_SEL_DIV = 3'b110;

endpackage

// File: rtl/alu_divider_if.sv
`timescale 1ns/100ps
// alu_divider_if
//   Request/response bundle between the execute stage (master) and the
//   divider (slave).
//     start       request, sampled while the divider is idle
//     dividend    numerator
//     divisor     denominator
//     signed_op   1 = two's-complement, 0 = unsigned
//     quotient    registered quotient
//     remainder   registered remainder
//     busywait    stall for PC / register writes while an op is in flight
//     done        one-cycle pulse when results become valid
//     div_by_zero registered with results, set when the divisor was zero
interface alu_divider_if
    import alu_divider_pkg::*;
#(parameter int WIDTH = DIV_WIDTH);

    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             signed_op;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             busywait;
    logic             done;
    logic             div_by_zero;

    modport master (
        output start, dividend, divisor, signed_op,
        input  quotient, remainder, busywait, done, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor, signed_op,
        output quotient, remainder, busywait, done, div_by_zero
    );

endinterface

// File: rtl/alu_divider_div_step.sv
`timescale 1ns/100ps
// alu_divider_div_step
//   One combinational restoring-division step.
//     prem      partial remainder (always < dsr)
//     nbit      next dividend bit, MSB first
//     dsr       divisor magnitude
//     prem_nxt  updated partial remainder
//     qbit      quotient bit produced by this step
module alu_divider_div_step
    import alu_divider_pkg::*;
#(parameter int WIDTH = DIV_WIDTH)
(
    input  logic [WIDTH-1:0] prem,
    input  logic             nbit,
    input  logic [WIDTH-1:0] dsr,
    output logic [WIDTH-1:0] prem_nxt,
    output logic             qbit
);

    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;

    // One extra bit holds the shifted remainder, which can reach 2*dsr-1.
    assign shifted = {prem, nbit};
    assign qbit    = (shifted >= {1'b0, dsr});
    // When the trial succeeds the true difference is < dsr, so the low
    // WIDTH bits of the subtraction are exact.
    assign diff     = shifted[WIDTH-1:0] - dsr;
    assign prem_nxt = qbit ? diff : shifted[WIDTH-1:0];

endmodule

// File: rtl/alu_divider.sv
`timescale 1ns/100ps
// alu_divider
//   Multi-cycle restoring divider, one quotient bit per clock, signed and
//   unsigned. An accepted request raises busywait immediately; results and
//   a one-cycle done pulse appear WIDTH+1 edges later (1 edge for a zero
//   divisor). Outputs are registered on the rising clk edge.
//     clk  system clock, rising edge
//     rst  asynchronous active-high reset; abandons any operation
//     bus  alu_divider_if slave port (request operands / results)
module alu_divider
    import alu_divider_pkg::*;
#(parameter int WIDTH = DIV_WIDTH)
(
    input  logic          clk,
    input  logic          rst,
    alu_divider_if.slave  bus
);

    localparam int CNT_W = $clog2(WIDTH);

    div_state_e state, state_nxt;

    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] dvd_sh, dsr_mag, prem, qsh, dvd_raw;
    logic             q_neg, r_neg, zflag;
    logic [WIDTH-1:0] quotient_r, remainder_r;
    logic             done_r, dbz_r;

    logic             dvd_neg, dsr_neg;
    logic [WIDTH-1:0] dvd_abs, dsr_abs;
    logic [WIDTH-1:0] prem_nxt;
    logic             qbit;

    // Magnitudes as unsigned WIDTH-bit values: abs(-2^(WIDTH-1)) wraps to
    // the bit pattern 2^(WIDTH-1), which is exactly the magnitude.
    assign dvd_neg = bus.signed_op & bus.dividend[WIDTH-1];
    assign dsr_neg = bus.signed_op & bus.divisor[WIDTH-1];
    assign dvd_abs = dvd_neg ? (~bus.dividend + 1'b1) : bus.dividend;
    assign dsr_abs = dsr_neg ? (~bus.divisor + 1'b1) : bus.divisor;

    alu_divider_div_step #(.WIDTH(WIDTH)) u_step (
        .prem     (prem),
        .nbit     (dvd_sh[WIDTH-1]),
        .dsr      (dsr_mag),
        .prem_nxt (prem_nxt),
        .qbit     (qbit)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (bus.start) state_nxt = (bus.divisor == '0) ? FIX : CALC;
            CALC: if (cnt == CNT_W'(WIDTH-1)) state_nxt = FIX;
            FIX:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt         <= '0;
            dvd_sh      <= '0;
            dsr_mag     <= '0;
            prem        <= '0;
            qsh         <= '0;
            dvd_raw     <= '0;
            q_neg       <= 1'b0;
            r_neg       <= 1'b0;
            zflag       <= 1'b0;
            quotient_r  <= '0;
            remainder_r <= '0;
            done_r      <= 1'b0;
            dbz_r       <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: if (bus.start) begin
                    dvd_sh  <= dvd_abs;
                    dsr_mag <= dsr_abs;
                    dvd_raw <= bus.dividend;
                    q_neg   <= dvd_neg ^ dsr_neg;
                    r_neg   <= dvd_neg;
                    zflag   <= (bus.divisor == '0);
                    prem    <= '0;
                    qsh     <= '0;
                    cnt     <= '0;
                end
                CALC: begin
                    prem   <= prem_nxt;
                    qsh    <= {qsh[WIDTH-2:0], qbit};
                    dvd_sh <= {dvd_sh[WIDTH-2:0], 1'b0};
                    cnt    <= cnt + 1'b1;
                end
                FIX: begin
                    done_r <= 1'b1;
                    dbz_r  <= zflag;
                    if (zflag) begin
                        quotient_r  <= '1;
                        remainder_r <= dvd_raw;
                    end else begin
                        quotient_r  <= q_neg ? (~qsh + 1'b1) : qsh;
                        remainder_r <= r_neg ? (~prem + 1'b1) : prem;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.quotient    = quotient_r;
    assign bus.remainder   = remainder_r;
    assign bus.done        = done_r;
    assign bus.div_by_zero = dbz_r;
    assign bus.busywait    = (state != IDLE);

endmodule
